// File: rtl/pll_clkdiv_pkg.sv
// Shared types and helpers for the PLL clock-divider bank: FSM states,
// per-channel configuration record and the counter preset calculation.
package pll_clkdiv_pkg;

  // Config fields are carried at this width; DIV_W of the bank must not exceed it.
  localparam int DIV_MAX_W = 16;
  localparam logic [DIV_MAX_W-1:0] DIV_ZERO = 16'd0;
  localparam logic [DIV_MAX_W-1:0] DIV_ONE  = 16'd1;

  typedef enum logic [1:0] {
    ST_RESET  = 2'd0,
    ST_ALIGN  = 2'd1,
    ST_SETTLE = 2'd2,
    ST_LOCKED = 2'd3
  } clkdiv_state_e;

  typedef struct packed {
    logic [DIV_MAX_W-1:0] div;
    logic [DIV_MAX_W-1:0] phase;
  } chan_cfg_t;

  function automatic logic [DIV_MAX_W-1:0] clamp_phase(input chan_cfg_t cfg);
    logic [DIV_MAX_W-1:0] p;
    if (cfg.div == DIV_ZERO) begin
      p = DIV_ZERO;
    end else if (cfg.phase >= cfg.div) begin
      p = cfg.div - DIV_ONE;
    end else begin
      p = cfg.phase;
    end
    return p;
  endfunction

  // Counter value after ALIGN such that it reaches 0 exactly `phase` cycles later.
  function automatic logic [DIV_MAX_W-1:0] preset_cnt(input chan_cfg_t cfg);
    logic [DIV_MAX_W-1:0] p;
    logic [DIV_MAX_W-1:0] r;
    p = clamp_phase(cfg);
    if (p == DIV_ZERO) begin
      r = DIV_ZERO;
    end else begin
      r = cfg.div - p;
    end
    return r;
  endfunction

endpackage

// File: rtl/pll_clkdiv_chan.sv
// One divider channel: active ratio register, wrapping counter with phase
// preset on align, and registered outclk / outclk_en.
module pll_clkdiv_chan
  import pll_clkdiv_pkg::*;
#(
  parameter int DIV_W = 8
) (
  input  logic             refclk,
  input  logic             rst,
  input  logic             align,
  input  logic [DIV_W-1:0] div,
  input  logic [DIV_W-1:0] phase,
  output logic             outclk,
  output logic             outclk_en
);

  localparam logic [DIV_W-1:0] CNT_ZERO = {DIV_W{1'b0}};
  localparam logic [DIV_W-1:0] CNT_ONE  = DIV_W'(1'b1);

  chan_cfg_t        cfg_s;
  logic [DIV_W:0]   half_s;
  logic [DIV_W-1:0] div_q, div_d;
  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic             started_q, started_d;
  logic             outclk_q, outclk_d;
  logic             outclk_en_q, outclk_en_d;

  // Next counter state; outputs are derived from the next count so they register in step.
  always_comb begin
    cfg_s     = '{div: DIV_MAX_W'(div), phase: DIV_MAX_W'(phase)};
    div_d     = div_q;
    cnt_d     = cnt_q;
    started_d = started_q;
    if (align) begin
      div_d     = div;
      cnt_d     = DIV_W'(preset_cnt(cfg_s));
      started_d = (cnt_d == CNT_ZERO);
    end else if (div_q == CNT_ZERO) begin
      cnt_d     = CNT_ZERO;
      started_d = 1'b0;
    end else begin
      if (cnt_q >= div_q - CNT_ONE) begin
        cnt_d = CNT_ZERO;
      end else begin
        cnt_d = cnt_q + CNT_ONE;
      end
      started_d = started_q | (cnt_d == CNT_ZERO);
    end
    half_s      = ({1'b0, div_d} + {{DIV_W{1'b0}}, 1'b1}) >> 1'b1;
    outclk_en_d = (div_d != CNT_ZERO) && (cnt_d == CNT_ZERO);
    // Held low until the first wrap so the first rise lands on the phase point.
    outclk_d    = (div_d != CNT_ZERO) && started_d && ({1'b0, cnt_d} < half_s);
  end

  // Channel state and output registers.
  always_ff @(posedge refclk or negedge rst) begin
    if (!rst) begin
      div_q       <= CNT_ZERO;
      cnt_q       <= CNT_ZERO;
      started_q   <= 1'b0;
      outclk_q    <= 1'b0;
      outclk_en_q <= 1'b0;
    end else begin
      div_q       <= div_d;
      cnt_q       <= cnt_d;
      started_q   <= started_d;
      outclk_q    <= outclk_d;
      outclk_en_q <= outclk_en_d;
    end
  end

  assign outclk    = outclk_q;
  assign outclk_en = outclk_en_q;

endmodule

// File: rtl/pll_clkdiv_bank.sv
// Clock-divider bank: shadow config registers with valid/ready write port,
// align/settle/lock supervision FSM and NUM_CLKS divider channels.
module pll_clkdiv_bank
  import pll_clkdiv_pkg::*;
#(
  parameter int NUM_CLKS    = 2,
  parameter int DIV_W       = 8,
  parameter int LOCK_CYCLES = 16,
  parameter int DEF_DIV     = 12,
  localparam int CHAN_W     = (NUM_CLKS > 1) ? $clog2(NUM_CLKS) : 1
) (
  input  logic                refclk,
  input  logic                rst,
  input  logic                cfg_valid,
  output logic                cfg_ready,
  input  logic [CHAN_W-1:0]   cfg_chan,
  input  logic [DIV_W-1:0]    cfg_div,
  input  logic [DIV_W-1:0]    cfg_phase,
  input  logic                commit,
  output logic [NUM_CLKS-1:0] outclk,
  output logic [NUM_CLKS-1:0] outclk_en,
  output logic                locked
);

  localparam int LCNT_W = $clog2(LOCK_CYCLES + 1);
  localparam logic [LCNT_W-1:0] LCNT_ZERO = {LCNT_W{1'b0}};
  localparam logic [LCNT_W-1:0] LCNT_ONE  = LCNT_W'(1'b1);
  localparam logic [LCNT_W-1:0] LCNT_LAST = LCNT_W'(LOCK_CYCLES - 1);
  localparam logic [DIV_W-1:0]  DIV_DEF   = DIV_W'(DEF_DIV);
  localparam logic [DIV_W-1:0]  PH_ZERO   = {DIV_W{1'b0}};

  clkdiv_state_e                  state_q, state_d;
  logic [LCNT_W-1:0]              lock_cnt_q, lock_cnt_d;
  logic                           cfg_ready_q, cfg_ready_d;
  logic                           locked_q, locked_d;
  logic [NUM_CLKS-1:0][DIV_W-1:0] sh_div_q, sh_div_d;
  logic [NUM_CLKS-1:0][DIV_W-1:0] sh_phase_q, sh_phase_d;
  logic                           cfg_wr_s;
  logic                           align_s;

  assign cfg_wr_s = cfg_valid & cfg_ready_q;
  assign align_s  = (state_q == ST_ALIGN);

  // Shadow config write; out-of-range channel numbers match no entry and are dropped.
  always_comb begin
    sh_div_d   = sh_div_q;
    sh_phase_d = sh_phase_q;
    for (int i = 0; i < NUM_CLKS; i++) begin
      if (cfg_wr_s && (cfg_chan == CHAN_W'(i))) begin
        sh_div_d[i]   = cfg_div;
        sh_phase_d[i] = cfg_phase;
      end else begin
        sh_div_d[i]   = sh_div_q[i];
        sh_phase_d[i] = sh_phase_q[i];
      end
    end
  end

  // Supervision FSM next state; commit in ALIGN is ignored, in SETTLE restarts the count.
  always_comb begin
    state_d    = state_q;
    lock_cnt_d = lock_cnt_q;
    case (state_q)
      ST_RESET: begin
        state_d = ST_ALIGN;
      end
      ST_ALIGN: begin
        state_d    = ST_SETTLE;
        lock_cnt_d = LCNT_ZERO;
      end
      ST_SETTLE: begin
        if (commit) begin
          state_d = ST_ALIGN;
        end else if (lock_cnt_q == LCNT_LAST) begin
          state_d = ST_LOCKED;
        end else begin
          lock_cnt_d = lock_cnt_q + LCNT_ONE;
        end
      end
      ST_LOCKED: begin
        if (commit) begin
          state_d = ST_ALIGN;
        end else begin
          state_d = ST_LOCKED;
        end
      end
      default: begin
        state_d = ST_RESET;
      end
    endcase
    cfg_ready_d = (state_d != ST_ALIGN);
    locked_d    = (state_d == ST_LOCKED);
  end

  // Control and shadow registers.
  always_ff @(posedge refclk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_RESET;
      lock_cnt_q  <= LCNT_ZERO;
      cfg_ready_q <= 1'b0;
      locked_q    <= 1'b0;
      sh_div_q    <= {NUM_CLKS{DIV_DEF}};
      sh_phase_q  <= {NUM_CLKS{PH_ZERO}};
    end else begin
      state_q     <= state_d;
      lock_cnt_q  <= lock_cnt_d;
      cfg_ready_q <= cfg_ready_d;
      locked_q    <= locked_d;
      sh_div_q    <= sh_div_d;
      sh_phase_q  <= sh_phase_d;
    end
  end

  assign cfg_ready = cfg_ready_q;
  assign locked    = locked_q;

  for (genvar g = 0; g < NUM_CLKS; g++) begin : g_chan
    pll_clkdiv_chan #(
      .DIV_W(DIV_W)
    ) u_chan (
      .refclk   (refclk),
      .rst      (rst),
      .align    (align_s),
      .div      (sh_div_q[g]),
      .phase    (sh_phase_q[g]),
      .outclk   (outclk[g]),
      .outclk_en(outclk_en[g])
    );
  end

endmodule
